// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: grant encoding and default widths shared by the writeback arbiter.
package wb_arb_pkg;
   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      GRANT_ALU = 2'b01,
      DRAIN_LD  = 2'b10
   } grant_t;
   localparam int WB_DATA_WIDTH     = 32;
   localparam int WB_REG_ADDR_WIDTH = 5;
endpackage

// File: rtl/wb_ld_fifo.sv
// wb_ld_fifo: in-order load-return buffer of {rd, data}.
// Exposes every stored rd plus its valid bit so the arbiter can detect WAW hazards.
module wb_ld_fifo import wb_arb_pkg::*; #(
   parameter int DW    = WB_DATA_WIDTH,
   parameter int AW    = WB_REG_ADDR_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [AW-1:0]                push_rd,
   input  logic [DW-1:0]                push_data,
   input  logic                         pop,
   output logic [AW-1:0]                head_rd,
   output logic [DW-1:0]                head_data,
   output logic [$clog2(DEPTH):0]       count,
   output logic [DEPTH-1:0][AW-1:0]     entry_rd,
   output logic [DEPTH-1:0]             entry_valid
);
   localparam int PW = $clog2(DEPTH);
   logic [PW-1:0]                wptr, rptr;
   logic [DEPTH-1:0][AW-1:0]     rd_mem;
   logic [DEPTH-1:0][DW-1:0]     data_mem;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= push ? wptr + 1'b1 : wptr;
         rptr  <= pop ? rptr + 1'b1 : rptr;
         count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      end
   end
   // Payload needs no reset: entry_valid masks stale slots.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem[wptr]   <= push_rd;
         data_mem[wptr] <= push_data;
      end
   end
   always_comb begin
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++)
         entry_valid[i] = {1'b0, PW'(i) - rptr} < count;
   end
   assign entry_rd  = rd_mem;
   assign head_rd   = rd_mem[rptr];
   assign head_data = data_mem[rptr];
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: shares the register-file write port between the ALU path and buffered load returns.
// Define WB_ARB_STATS_EN to add saturating stall/full-cycle counters.
module wb_write_arbiter import wb_arb_pkg::*; #(
   parameter int DATA_WIDTH     = WB_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
   parameter int LD_DEPTH       = 2,
   parameter int MAX_WAIT       = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      alu_valid,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]     alu_data,
   output logic                      alu_stall,
   input  logic                      ld_valid,
   input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
   input  logic [DATA_WIDTH-1:0]     ld_data,
   output logic                      ld_ready,
   output logic                      rf_we,
   output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0]     rf_wdata
`ifdef WB_ARB_STATS_EN
   ,
   output logic [31:0]               alu_stall_cnt,
   output logic [31:0]               ld_full_cnt
`endif
);
   localparam int CW  = $clog2(LD_DEPTH) + 1;
   localparam int AGW = $clog2(MAX_WAIT + 1);
   logic [CW-1:0]                             count;
   logic [REG_ADDR_WIDTH-1:0]                 head_rd;
   logic [DATA_WIDTH-1:0]                     head_data;
   logic [LD_DEPTH-1:0][REG_ADDR_WIDTH-1:0]   entry_rd;
   logic [LD_DEPTH-1:0]                       entry_valid;
   logic [AGW-1:0]                            age;
   logic                                      full, empty, waw, push, pop, alu_wr;
   grant_t                                    grant;
   wb_ld_fifo #(.DW(DATA_WIDTH), .AW(REG_ADDR_WIDTH), .DEPTH(LD_DEPTH)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push(push), .push_rd(ld_rd), .push_data(ld_data),
      .pop(pop), .head_rd(head_rd), .head_data(head_data), .count(count),
      .entry_rd(entry_rd), .entry_valid(entry_valid)
   );
   assign full     = count == CW'(LD_DEPTH);
   assign empty    = count == '0;
   assign ld_ready = !full;
   assign push     = ld_valid && ld_ready && ld_rd != '0;
   // rd 0 is never stored, so an ALU write to x0 can never match here.
   always_comb begin
      waw = 1'b0;
      for (int i = 0; i < LD_DEPTH; i++)
         waw = waw | (entry_valid[i] && entry_rd[i] == alu_rd);
   end
   always_comb begin
      grant = (!empty && (!alu_valid || full || age == AGW'(MAX_WAIT) || waw)) ? DRAIN_LD :
              alu_valid ? GRANT_ALU : IDLE;
   end
   assign pop       = grant == DRAIN_LD;
   assign alu_wr    = grant == GRANT_ALU && alu_rd != '0;
   assign alu_stall = alu_valid && alu_rd != '0 && pop;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         age      <= '0;
      end else begin
         rf_we    <= pop || alu_wr;
         rf_waddr <= pop ? head_rd : alu_wr ? alu_rd : rf_waddr;
         rf_wdata <= pop ? head_data : alu_wr ? alu_data : rf_wdata;
         age      <= (pop || empty) ? '0 : age == AGW'(MAX_WAIT) ? age : age + 1'b1;
      end
   end
`ifdef WB_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_stall_cnt <= '0;
         ld_full_cnt   <= '0;
      end else begin
         alu_stall_cnt <= (alu_stall && ~&alu_stall_cnt) ? alu_stall_cnt + 1'b1 : alu_stall_cnt;
         ld_full_cnt   <= (full && ~&ld_full_cnt) ? ld_full_cnt + 1'b1 : ld_full_cnt;
      end
   end
`endif
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed self-checking bench for wb_write_arbiter (default parameters).
module tb_wb_write_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = '0;
   logic [31:0] alu_data = '0;
   logic        alu_stall;
   logic        ld_valid = 1'b0;
   logic [4:0]  ld_rd = '0;
   logic [31:0] ld_data = '0;
   logic        ld_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
   logic [31:0] alu_stall_cnt, ld_full_cnt;
`endif
   int checks = 0;
   int failures = 0;

   wb_write_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef WB_ARB_STATS_EN
      , .alu_stall_cnt(alu_stall_cnt), .ld_full_cnt(ld_full_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== 38'd0) begin
         failures++;
         $display("FAIL reset_rf: got we=%b addr=%0d data=%h, need 0/0/0", rf_we, rf_waddr, rf_wdata);
      end
      checks++;
      if ({ld_ready, alu_stall} !== 2'b10) begin
         failures++;
         $display("FAIL reset_flags: got ready=%b stall=%b, need 1/0", ld_ready, alu_stall);
      end
`ifdef WB_ARB_STATS_EN
      checks++;
      if ({alu_stall_cnt, ld_full_cnt} !== 64'd0) begin
         failures++;
         $display("FAIL reset_stats: got %0d/%0d, need 0/0", alu_stall_cnt, ld_full_cnt);
      end
`endif
      rst_n = 1'b1;
      tick;
      checks++;
      if (rf_we !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_we: got %b, need 0", rf_we);
      end
   endtask

   task automatic test_alu_path;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (alu_stall !== 1'b0) begin
            failures++;
            $display("FAIL alu_stall c%0d: got %b, need 0", c, alu_stall);
         end
         tick;
         checks++;
         if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin
            failures++;
            $display("FAIL alu_write c%0d: got %b/%0d/%h, need 1/3/11", c, rf_we, rf_waddr, rf_wdata);
         end
      end
      alu_valid = 1'b0;
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h11}) begin
         failures++;
         $display("FAIL alu_idle_hold: got %b/%0d/%h, need 0/3/11", rf_we, rf_waddr, rf_wdata);
      end
   endtask

   task automatic test_load_idle;
      ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hAA;
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL ld_ready_empty: got %b, need 1", ld_ready);
      end
      tick;
      ld_valid = 1'b0;
      checks++;
      if (rf_we !== 1'b0) begin
         failures++;
         $display("FAIL ld_no_bypass: got we=%b, need 0", rf_we);
      end
      #1;
      checks++;
      if (ld_ready !== 1'b1) begin
         failures++;
         $display("FAIL ld_ready_one: got %b, need 1", ld_ready);
      end
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hAA}) begin
         failures++;
         $display("FAIL ld_write: got %b/%0d/%h, need 1/5/aa", rf_we, rf_waddr, rf_wdata);
      end
      tick;
      checks++;
      if (rf_we !== 1'b0) begin
         failures++;
         $display("FAIL ld_after: got we=%b, need 0", rf_we);
      end
   endtask

   task automatic test_full_and_age;
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h21;
      ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'h66;
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h21}) begin
         failures++;
         $display("FAIL full_alu0: got %b/%0d/%h, need 1/1/21", rf_we, rf_waddr, rf_wdata);
      end
      ld_rd = 5'd7; ld_data = 32'h77;
      #1;
      checks++;
      if ({ld_ready, alu_stall} !== 2'b10) begin
         failures++;
         $display("FAIL full_second_accept: got ready=%b stall=%b, need 1/0", ld_ready, alu_stall);
      end
      tick;
      ld_valid = 1'b0;
      #1;
      checks++;
      if ({ld_ready, alu_stall} !== 2'b01) begin
         failures++;
         $display("FAIL full_state: got ready=%b stall=%b, need 0/1", ld_ready, alu_stall);
      end
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h66}) begin
         failures++;
         $display("FAIL full_drain: got %b/%0d/%h, need 1/6/66", rf_we, rf_waddr, rf_wdata);
      end
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (alu_stall !== 1'b0) begin
            failures++;
            $display("FAIL age_wait_stall c%0d: got %b, need 0", c, alu_stall);
         end
         tick;
         checks++;
         if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h21}) begin
            failures++;
            $display("FAIL age_wait_alu c%0d: got %b/%0d/%h, need 1/1/21", c, rf_we, rf_waddr, rf_wdata);
         end
      end
      #1;
      checks++;
      if (alu_stall !== 1'b1) begin
         failures++;
         $display("FAIL age_force_stall: got %b, need 1", alu_stall);
      end
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin
         failures++;
         $display("FAIL age_force_drain: got %b/%0d/%h, need 1/7/77", rf_we, rf_waddr, rf_wdata);
      end
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'h21}) begin
         failures++;
         $display("FAIL age_resume: got %b/%0d/%h, need 1/1/21", rf_we, rf_waddr, rf_wdata);
      end
      alu_valid = 1'b0;
      tick;
   endtask

   task automatic test_waw;
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
      tick;
      ld_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h55;
      #1;
      checks++;
      if (alu_stall !== 1'b1) begin
         failures++;
         $display("FAIL waw_stall: got %b, need 1", alu_stall);
      end
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
         failures++;
         $display("FAIL waw_load_first: got %b/%0d/%h, need 1/9/99", rf_we, rf_waddr, rf_wdata);
      end
      #1;
      checks++;
      if (alu_stall !== 1'b0) begin
         failures++;
         $display("FAIL waw_release: got %b, need 0", alu_stall);
      end
      tick;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h55}) begin
         failures++;
         $display("FAIL waw_alu_second: got %b/%0d/%h, need 1/9/55", rf_we, rf_waddr, rf_wdata);
      end
      alu_valid = 1'b0;
      tick;
   endtask

   task automatic test_rd_zero;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
      ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h88;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if ({ld_ready, alu_stall} !== 2'b10) begin
            failures++;
            $display("FAIL rd0_flags c%0d: got ready=%b stall=%b, need 1/0", c, ld_ready, alu_stall);
         end
         tick;
         checks++;
         if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rd0_we c%0d: got %b, need 0", c, rf_we);
         end
      end
      alu_valid = 1'b0; ld_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick;
         checks++;
         if (rf_we !== 1'b0) begin
            failures++;
            $display("FAIL rd0_not_stored c%0d: got we=%b, need 0", c, rf_we);
         end
      end
   endtask

   task automatic test_reset_mid;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
      ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA0;
      tick;
      ld_rd = 5'd11; ld_data = 32'hB0;
      tick;
      alu_valid = 1'b0; ld_valid = 1'b0;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h22}) begin
         failures++;
         $display("FAIL rst_pre: got %b/%0d/%h, need 1/2/22", rf_we, rf_waddr, rf_wdata);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, ld_ready} !== {1'b0, 5'd0, 32'h0, 1'b1}) begin
         failures++;
         $display("FAIL rst_async: got %b/%0d/%h ready=%b, need 0/0/0 ready=1", rf_we, rf_waddr, rf_wdata, ld_ready);
      end
      repeat (2) tick;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick;
         checks++;
         if ({rf_we, ld_ready} !== 2'b01) begin
            failures++;
            $display("FAIL rst_no_stale c%0d: got we=%b ready=%b, need 0/1", c, rf_we, ld_ready);
         end
      end
`ifdef WB_ARB_STATS_EN
      checks++;
      if ({alu_stall_cnt, ld_full_cnt} !== 64'd0) begin
         failures++;
         $display("FAIL rst_stats: got %0d/%0d, need 0/0", alu_stall_cnt, ld_full_cnt);
      end
`endif
   endtask

   initial begin
      test_reset;
      test_alu_path;
      test_load_idle;
      test_full_and_age;
      test_waw;
      test_rd_zero;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
